// File: rtl/counter_step_pkg.sv
// Shared types and helpers for the counter step controller.
// Optional hold-to-repeat is enabled with the COUNTER_STEP_HOLD_REPEAT_EN macro.
package counter_step_pkg;

  typedef enum logic [1:0] {
    DEB_IDLE,
    DEB_PRESS_WAIT,
    DEB_PRESSED,
    DEB_RELEASE_WAIT
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

  // One counter width shared by debounce and repeat timing, so every count fits without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw pushbutton.
// The pressed output exists only when COUNTER_STEP_HOLD_REPEAT_EN is defined.
module btn_debounce
  import counter_step_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_pulse,
  output logic held
`ifdef COUNTER_STEP_HOLD_REPEAT_EN
  , output logic pressed
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  deb_state_t             state;
  logic [CNT_W-1:0]       count;

  assign sync = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn};
  end

  // count tracks stable samples in the current wait state and never exceeds LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DEB_IDLE;
      count <= '0;
    end else begin
      case (state)
        DEB_IDLE: begin
          if (sync) begin
            state <= DEB_PRESS_WAIT;
            count <= CNT_W'(1);
          end
        end
        DEB_PRESS_WAIT: begin
          if (!sync) begin
            state <= DEB_IDLE;
            count <= '0;
          end else if (count >= LAST) begin
            state <= DEB_PRESSED;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DEB_PRESSED: begin
          if (!sync) begin
            state <= DEB_RELEASE_WAIT;
            count <= CNT_W'(1);
          end
        end
        DEB_RELEASE_WAIT: begin
          if (sync) begin
            state <= DEB_PRESSED;
            count <= '0;
          end else if (count >= LAST) begin
            state <= DEB_IDLE;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= DEB_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Pulse on the accepting sample itself so the output register lands on the same edge.
  assign press_pulse = (state == DEB_PRESS_WAIT) && sync && (count >= LAST);
  assign held        = (state == DEB_PRESSED) || (state == DEB_RELEASE_WAIT);
`ifdef COUNTER_STEP_HOLD_REPEAT_EN
  assign pressed     = (state == DEB_PRESSED);
`endif

endmodule

// File: rtl/counter_step_ctrl.sv
// Turns two bouncing buttons into single-cycle ena/up steps for the up/down counter.
// Define COUNTER_STEP_HOLD_REPEAT_EN to add auto-repeat while one button is held.
module counter_step_ctrl
  import counter_step_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  output logic ena,
  output logic up
);

  localparam int CNT_W = cnt_width(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  logic up_pulse, up_held, dn_pulse, dn_held;
  logic rep_up, rep_dn, up_evt, dn_evt;
`ifdef COUNTER_STEP_HOLD_REPEAT_EN
  logic up_pressed, dn_pressed;
`endif

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
    .clk(clk), .rst(rst), .btn(btn_up), .press_pulse(up_pulse), .held(up_held)
`ifdef COUNTER_STEP_HOLD_REPEAT_EN
    , .pressed(up_pressed)
`endif
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_dn (
    .clk(clk), .rst(rst), .btn(btn_dn), .press_pulse(dn_pulse), .held(dn_held)
`ifdef COUNTER_STEP_HOLD_REPEAT_EN
    , .pressed(dn_pressed)
`endif
  );

`ifdef COUNTER_STEP_HOLD_REPEAT_EN
  logic             up_only, dn_only, rep_run, rep_fire, rep_started;
  logic [CNT_W-1:0] rep_cnt, rep_target;

  assign up_only    = up_pressed && !dn_held;
  assign dn_only    = dn_pressed && !up_held;
  assign rep_run    = up_only || dn_only;
  assign rep_target = rep_started ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
  assign rep_fire   = rep_run && (rep_cnt == rep_target);
  assign rep_up     = rep_fire && up_only;
  assign rep_dn     = rep_fire && dn_only;

  // Leaving sole-pressed (release wait or the other button held) restarts the delay from scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt     <= '0;
      rep_started <= 1'b0;
    end else if (!rep_run) begin
      rep_cnt     <= '0;
      rep_started <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt     <= '0;
      rep_started <= 1'b1;
    end else if (rep_cnt != '1) begin
      rep_cnt <= rep_cnt + CNT_W'(1);
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign up_evt = up_pulse || rep_up;
  assign dn_evt = dn_pulse || rep_dn;

  // Only an unambiguous single-direction request produces a step; up holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena <= 1'b0;
      up  <= 1'b1;
    end else begin
      ena <= 1'b0;
      if (up_evt && !dn_evt && !dn_held) begin
        ena <= 1'b1;
        up  <= 1'b1;
      end else if (dn_evt && !up_evt && !up_held) begin
        ena <= 1'b1;
        up  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed self-checking bench for counter_step_ctrl (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Repeat expectations follow COUNTER_STEP_HOLD_REPEAT_EN.
module tb_counter_step_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_up;
  logic btn_dn;
  logic ena;
  logic up;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;
  int doubles  = 0;
  logic prev_ena = 1'b0;
  int pulse_edge[$];
  int pulse_up[$];

  counter_step_ctrl #(.DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .ena(ena), .up(up)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic start_test();
    edge_no  = 0;
    doubles  = 0;
    prev_ena = 1'b0;
    pulse_edge.delete();
    pulse_up.delete();
  endtask

  // Hold the buttons for n edges, logging every ena pulse by edge number.
  task automatic apply_stimulus(input logic u, input logic d, input int n);
    btn_up = u;
    btn_dn = d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (ena === 1'b1) begin
        pulse_edge.push_back(edge_no);
        pulse_up.push_back(int'(up));
        if (prev_ena) doubles++;
      end
      prev_ena = ena;
    end
  endtask

  function automatic int edge_at(input int i);
    return (i < pulse_edge.size()) ? pulse_edge[i] : -1;
  endfunction

  function automatic int up_at(input int i);
    return (i < pulse_up.size()) ? pulse_up[i] : -1;
  endfunction

  int exp_edges[$];

  initial begin
    rst    = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_output("reset_ena", int'(ena), 0);
    check_output("reset_up", int'(up), 1);
    rst = 1'b0;

    // 1: idle
    start_test();
    apply_stimulus(1'b0, 1'b0, 10);
    check_output("idle_pulses", pulse_edge.size(), 0);
    check_output("idle_up", int'(up), 1);

    // 2: bouncing up press, then bouncing release
    start_test();
    apply_stimulus(1'b1, 1'b0, 3);
    apply_stimulus(1'b0, 1'b0, 1);
    apply_stimulus(1'b1, 1'b0, 20);
    check_output("bounce_pulses", pulse_edge.size(), 1);
    check_output("bounce_edge", edge_at(0), 10);
    check_output("bounce_up", up_at(0), 1);
    start_test();
    apply_stimulus(1'b0, 1'b0, 2);
    apply_stimulus(1'b1, 1'b0, 1);
    apply_stimulus(1'b0, 1'b0, 12);
    check_output("release_pulses", pulse_edge.size(), 0);

    // 3: clean down press
    start_test();
    apply_stimulus(1'b0, 1'b1, 10);
    apply_stimulus(1'b0, 1'b0, 20);
    check_output("dn_pulses", pulse_edge.size(), 1);
    check_output("dn_edge", edge_at(0), 6);
    check_output("dn_up", up_at(0), 0);
    check_output("dn_up_kept", int'(up), 0);

    // 4: simultaneous press, then down press while up held
    start_test();
    apply_stimulus(1'b1, 1'b1, 12);
    apply_stimulus(1'b1, 1'b0, 12);
    apply_stimulus(1'b1, 1'b1, 12);
    apply_stimulus(1'b0, 1'b0, 12);
    check_output("conflict_pulses", pulse_edge.size(), 0);
    check_output("conflict_up_kept", int'(up), 0);

    // 5: reset in the middle of a press wait
    start_test();
    apply_stimulus(1'b1, 1'b0, 4);
    rst = 1'b1;
    #2;
    check_output("async_rst_ena", int'(ena), 0);
    check_output("async_rst_up", int'(up), 1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    start_test();
    apply_stimulus(1'b1, 1'b0, 10);
    apply_stimulus(1'b0, 1'b0, 12);
    check_output("post_rst_pulses", pulse_edge.size(), 1);
    check_output("post_rst_edge", edge_at(0), 6);
    check_output("post_rst_up", up_at(0), 1);

    // 6: long hold of the up button
    start_test();
    apply_stimulus(1'b1, 1'b0, 66);
    apply_stimulus(1'b0, 1'b0, 20);
`ifdef COUNTER_STEP_HOLD_REPEAT_EN
    exp_edges = '{6, 26, 34, 42, 50, 58, 66};
`else
    exp_edges = '{6};
`endif
    check_output("hold_pulses", pulse_edge.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size(); i++) begin
      check_output($sformatf("hold_edge%0d", i), edge_at(i), exp_edges[i]);
      check_output($sformatf("hold_up%0d", i), up_at(i), 1);
    end
    check_output("hold_no_double", doubles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
